// File: rtl/tb_pkg.sv
// Shared definitions for the passthrough checker: FSM states, error-counter
// width and the saturating accumulate used by the error counter.
package tb_pkg;

    localparam int ERR_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Unsigned add that sticks at all-ones instead of wrapping.
    function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] a,
                                                 input logic [ERR_W-1:0] b);
        logic [ERR_W:0] sum_s;
        sum_s = {1'b0, a} + {1'b0, b};
        if (sum_s[ERR_W]) begin
            return {ERR_W{1'b1}};
        end else begin
            return sum_s[ERR_W-1:0];
        end
    endfunction

endpackage

// File: rtl/passthrough_checker_if.sv
// Stimulus/response bus between the checker (master) and the blackbox DUT
// (slave). Channel c occupies bits [c*WIDTH +: WIDTH] in both directions.
interface passthrough_checker_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    logic [CHANNELS*WIDTH-1:0] dut_in;
    logic [CHANNELS*WIDTH-1:0] dut_out;

    modport master (output dut_in, input dut_out);
    modport slave  (input dut_in, output dut_out);
endinterface

// File: rtl/delay_line.sv
// Fixed-depth shift register; synchronous active-low reset clears all stages.
module delay_line #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] stage_q [DEPTH];

    // Shift the payload one stage per clock, clearing everything on reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= {W{1'b0}};
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/passthrough_checker.sv
// Drives a counting vector sequence into a passthrough DUT and compares the
// response after LATENCY cycles, counting and locating mismatches.
module passthrough_checker
    import tb_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int CHANNELS    = 4,
    parameter int LATENCY     = 2,
    parameter int NUM_VECTORS = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 invert,
    passthrough_checker_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 fail_pulse,
    output logic [ERR_W-1:0]     err_count,
    output logic [15:0]          first_err_vec,
    output logic [3:0]           first_err_chan
);

    localparam int          CW         = CHANNELS * WIDTH;
    localparam int          DLW        = 1 + 16 + CW;
    localparam logic [15:0] LAST_VEC   = 16'(NUM_VECTORS - 1);
    localparam logic [3:0]  LAST_DRAIN = 4'(LATENCY - 1);

    state_t          state_q, state_d;
    logic [15:0]     vec_q, vec_d;
    logic [3:0]      drain_q, drain_d;
    logic            invert_q, invert_d;
    logic            valid_q, valid_d;
    logic [CW-1:0]   stim_q, stim_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [15:0]     fvec_q, fvec_d;
    logic [3:0]      fchan_q, fchan_d;
    logic            seen_q, seen_d;

    logic [DLW-1:0]  dl_in_s, dl_out_s;
    logic            dvalid_s;
    logic [15:0]     dvec_s;
    logic [CW-1:0]   dexp_s;
    logic [CHANNELS-1:0] mis_s;
    logic [4:0]      pop_s;
    logic [3:0]      low_chan_s;
    logic            any_mis_s;
    logic            run_start_s;

    // Stimulus for vector k: channel c carries (k*CHANNELS + c) mod 2^WIDTH.
    function automatic logic [CW-1:0] stim_of(input logic [15:0] k);
        logic [CW-1:0] v;
        v = {CW{1'b0}};
        for (int c = 0; c < CHANNELS; c++) begin
            v[c*WIDTH +: WIDTH] = WIDTH'(32'(k) * 32'(CHANNELS) + 32'(c));
        end
        return v;
    endfunction

    // Expected value travels alongside the stimulus so it lines up with dut_out.
    assign dl_in_s = {valid_q, vec_q, stim_q ^ {CW{invert_q}}};

    delay_line #(.W(DLW), .DEPTH(LATENCY)) u_delay (
        .clock (clock),
        .reset (reset),
        .d_i   (dl_in_s),
        .q_o   (dl_out_s)
    );

    assign dvalid_s = dl_out_s[DLW-1];
    assign dvec_s   = dl_out_s[CW +: 16];
    assign dexp_s   = dl_out_s[CW-1:0];

    // Per-channel compare, mismatch popcount and lowest mismatching channel.
    always_comb begin
        pop_s      = 5'd0;
        low_chan_s = 4'd0;
        mis_s      = {CHANNELS{1'b0}};
        for (int c = 0; c < CHANNELS; c++) begin
            mis_s[c] = dvalid_s &&
                       (bus.dut_out[c*WIDTH +: WIDTH] != dexp_s[c*WIDTH +: WIDTH]);
            pop_s    = pop_s + {4'd0, mis_s[c]};
        end
        for (int c = CHANNELS - 1; c >= 0; c--) begin
            low_chan_s = mis_s[c] ? 4'(c) : low_chan_s;
        end
        any_mis_s = |mis_s;
    end

    // Next-state, vector sequencing and error bookkeeping.
    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        drain_d     = drain_q;
        invert_d    = invert_q;
        valid_d     = 1'b0;
        stim_d      = {CW{1'b0}};
        err_d       = err_q;
        fvec_d      = fvec_q;
        fchan_d     = fchan_q;
        seen_d      = seen_q;
        run_start_s = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = RUN;
                    vec_d       = 16'd0;
                    invert_d    = invert;
                    valid_d     = 1'b1;
                    stim_d      = stim_of(16'd0);
                    run_start_s = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            RUN: begin
                if (vec_q == LAST_VEC) begin
                    state_d = DRAIN;
                    drain_d = 4'd0;
                end else begin
                    vec_d   = vec_q + 16'd1;
                    valid_d = 1'b1;
                    stim_d  = stim_of(vec_q + 16'd1);
                end
            end
            DRAIN: begin
                if (drain_q == LAST_DRAIN) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (run_start_s) begin
            err_d   = {ERR_W{1'b0}};
            fvec_d  = 16'd0;
            fchan_d = 4'd0;
            seen_d  = 1'b0;
        end else if (any_mis_s) begin
            err_d   = sat_add(err_q, ERR_W'(pop_s));
            fvec_d  = seen_q ? fvec_q : dvec_s;
            fchan_d = seen_q ? fchan_q : low_chan_s;
            seen_d  = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // State and result registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= IDLE;
            vec_q    <= 16'd0;
            drain_q  <= 4'd0;
            invert_q <= 1'b0;
            valid_q  <= 1'b0;
            stim_q   <= {CW{1'b0}};
            err_q    <= {ERR_W{1'b0}};
            fvec_q   <= 16'd0;
            fchan_q  <= 4'd0;
            seen_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            drain_q  <= drain_d;
            invert_q <= invert_d;
            valid_q  <= valid_d;
            stim_q   <= stim_d;
            err_q    <= err_d;
            fvec_q   <= fvec_d;
            fchan_q  <= fchan_d;
            seen_q   <= seen_d;
        end
    end

    assign bus.dut_in     = stim_q;
    assign busy           = (state_q == RUN) || (state_q == DRAIN);
    assign done           = (state_q == DONE);
    assign pass           = done && (err_q == {ERR_W{1'b0}});
    assign fail_pulse     = any_mis_s;
    assign err_count      = err_q;
    assign first_err_vec  = fvec_q;
    assign first_err_chan = fchan_q;

endmodule

// File: tb/tb_passthrough_checker.sv
// Scoreboard bench: each run pushes its expected result; per-DUT monitors pop
// and compare when done rises. Checker A (W8,L2) faces a configurable model,
// checker B (W4,L2) faces a model that is one cycle too slow.
module tb_passthrough_checker;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset, start_a, invert_a, start_b, invert_b;
    logic busy_a, done_a, pass_a, fail_a, busy_b, done_b, pass_b, fail_b;
    logic [15:0] err_a, fvec_a, err_b, fvec_b;
    logic [3:0]  fchan_a, fchan_b;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int model_mode = 0;

    typedef struct {
        int err; int pass; int fvec; int fchan; int dur; int nfail; int ffoff;
    } res_t;
    res_t q_a[$];
    res_t q_b[$];

    passthrough_checker_if #(.WIDTH(8), .CHANNELS(4)) bus_a ();
    passthrough_checker_if #(.WIDTH(4), .CHANNELS(4)) bus_b ();

    passthrough_checker #(.WIDTH(8), .CHANNELS(4), .LATENCY(2), .NUM_VECTORS(16)) dut_a (
        .clock(clock), .reset(reset), .start(start_a), .invert(invert_a), .bus(bus_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .fail_pulse(fail_a),
        .err_count(err_a), .first_err_vec(fvec_a), .first_err_chan(fchan_a));

    passthrough_checker #(.WIDTH(4), .CHANNELS(4), .LATENCY(2), .NUM_VECTORS(16)) dut_b (
        .clock(clock), .reset(reset), .start(start_b), .invert(invert_b), .bus(bus_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .fail_pulse(fail_b),
        .err_count(err_b), .first_err_vec(fvec_b), .first_err_chan(fchan_b));

    // Model A: two-stage passthrough; mode 1 inverts, mode 2 flips bit 0 of
    // channel 2 when it carries 22 (vector 5).
    function automatic logic [31:0] model_a_f(input logic [31:0] x, input int mode);
        logic [31:0] v;
        v = x;
        if (mode == 1) v = ~v;
        if (mode == 2 && v[23:16] == 8'd22) v[16] = ~v[16];
        return v;
    endfunction

    logic [31:0] ma1 = 32'd0, ma2 = 32'd0;
    logic [15:0] mb1 = 16'd0, mb2 = 16'd0, mb3 = 16'd0;

    // Behavioural DUT models.
    always_ff @(posedge clock) begin
        ma1 <= model_a_f(bus_a.dut_in, model_mode);
        ma2 <= ma1;
        mb1 <= bus_b.dut_in;
        mb2 <= mb1;
        mb3 <= mb2;
    end
    assign bus_a.dut_out = ma2;
    assign bus_b.dut_out = mb3;

    // Cycle counter.
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic monitor(input int sel);
        int rise = 0;
        int nfail = 0;
        int ffoff = -1;
        logic busy_p = 1'b0;
        logic done_p = 1'b0;
        logic bz, dn, fl;
        res_t e;
        string tag;
        tag = (sel == 1) ? "b" : "a";
        forever begin
            @(negedge clock);
            bz = (sel == 1) ? busy_b : busy_a;
            dn = (sel == 1) ? done_b : done_a;
            fl = (sel == 1) ? fail_b : fail_a;
            if (bz && !busy_p) begin
                rise = cyc; nfail = 0; ffoff = -1;
            end
            if (fl) begin
                if (ffoff < 0) ffoff = cyc - rise;
                nfail++;
            end
            if (dn && !done_p) begin
                if ((sel == 1 ? q_b.size() : q_a.size()) == 0) begin
                    check({tag, "_unexpected_done"}, 64'd1, 64'd0);
                end else begin
                    e = (sel == 1) ? q_b.pop_front() : q_a.pop_front();
                    check({tag, "_err_count"}, (sel == 1) ? err_b : err_a, e.err);
                    check({tag, "_pass"}, (sel == 1) ? pass_b : pass_a, e.pass);
                    check({tag, "_first_vec"}, (sel == 1) ? fvec_b : fvec_a, e.fvec);
                    check({tag, "_first_chan"}, (sel == 1) ? fchan_b : fchan_a, e.fchan);
                    check({tag, "_run_cycles"}, cyc - rise, e.dur);
                    check({tag, "_fail_pulses"}, nfail, e.nfail);
                    check({tag, "_first_fail_offset"}, ffoff, e.ffoff);
                end
            end
            busy_p = bz;
            done_p = dn;
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    task automatic wait_done(input string tag, input int sel);
        int n;
        n = 0;
        while (!((sel == 1) ? done_b : done_a) && n < 40) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_done_seen"}, (sel == 1) ? done_b : done_a, 1);
    endtask

    task automatic check_idle_a(input string tag);
        check({tag, "_busy"}, busy_a, 0);
        check({tag, "_done"}, done_a, 0);
        check({tag, "_pass"}, pass_a, 0);
        check({tag, "_fail_pulse"}, fail_a, 0);
        check({tag, "_err"}, err_a, 0);
        check({tag, "_fvec"}, fvec_a, 0);
        check({tag, "_fchan"}, fchan_a, 0);
        check({tag, "_dut_in"}, bus_a.dut_in, 0);
    endtask

    task automatic run_a(input string tag, input logic inv, input res_t e, input int mid);
        @(negedge clock);
        start_a = 1'b1; invert_a = inv;
        q_a.push_back(e);
        @(negedge clock);
        start_a = 1'b0; invert_a = 1'b0;
        check({tag, "_busy"}, busy_a, 1);
        check({tag, "_vec0"}, bus_a.dut_in, 32'h03020100);
        check({tag, "_err_clr"}, err_a, 0);
        @(negedge clock);
        check({tag, "_vec1"}, bus_a.dut_in, 32'h07060504);
        if (mid > 0) begin
            start_a = 1'b1; invert_a = 1'b1;
            @(negedge clock);
            start_a = 1'b0; invert_a = 1'b0;
            check({tag, "_ignored_start"}, bus_a.dut_in, 32'h0b0a0908);
            check({tag, "_busy_mid"}, busy_a, 1);
        end
        wait_done(tag, 0);
    endtask

    localparam res_t CLEAN = '{0, 1, 0, 0, 18, 0, -1};

    initial begin
        logic [15:0] exp_v;
        reset = 1'b0; start_a = 1'b0; invert_a = 1'b0; start_b = 1'b0; invert_b = 1'b0;
        repeat (3) @(negedge clock);
        check_idle_a("rst");
        start_a = 1'b1;
        @(negedge clock);
        check("rst_with_start_busy", busy_a, 0);
        start_a = 1'b0; reset = 1'b1;
        @(negedge clock);
        check("post_rst_busy", busy_a, 0);

        model_mode = 0; run_a("ideal", 1'b0, CLEAN, 0);
        model_mode = 1; run_a("inv_ok", 1'b1, CLEAN, 0);
        run_a("inv_bad", 1'b0, '{64, 0, 0, 0, 18, 16, 2}, 0);
        model_mode = 2; run_a("corrupt", 1'b0, '{1, 0, 5, 2, 18, 1, 7}, 0);
        @(negedge clock);
        check("corrupt_done_hold", done_a, 1);
        check("corrupt_err_hold", err_a, 1);
        model_mode = 0; run_a("restart", 1'b0, CLEAN, 1);

        // Abort a run with reset at cycle 8.
        @(negedge clock); start_a = 1'b1;
        @(negedge clock); start_a = 1'b0;
        repeat (7) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        check_idle_a("abort");
        run_a("after_abort", 1'b0, CLEAN, 0);

        // Checker B: WIDTH=4 wrap, DUT one cycle too slow.
        q_b.push_back('{63, 0, 0, 1, 18, 16, 2});
        @(negedge clock); start_b = 1'b1;
        @(negedge clock); start_b = 1'b0;
        for (int k = 0; k < 16; k++) begin
            for (int c = 0; c < 4; c++) exp_v[c*4 +: 4] = 4'((k * 4 + c) % 16);
            check($sformatf("b_vec%0d", k), bus_b.dut_in, exp_v);
            @(negedge clock);
        end
        check("b_drain_dut_in", bus_b.dut_in, 0);
        check("b_drain_busy", busy_b, 1);
        wait_done("b", 1);

        repeat (3) @(negedge clock);
        check("a_queue_empty", q_a.size(), 0);
        check("b_queue_empty", q_b.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule

// File: doc/passthrough_checker.md
# passthrough_checker

Self-checking stimulus/compare engine for multi-channel passthrough blackboxes. It drives a deterministic vector sequence into a DUT's input bus and compares the DUT output, after a fixed latency, against the expected value. It counts mismatches and reports pass/fail. It generalises the single-bit, single-cycle "drive 1, expect 1" blackbox test to N channels, configurable width, configurable pipeline latency and a passthrough/invert mode, and it sits beside the DUT in tester top-levels.

## Interface
Parameters:
- WIDTH, 8: bits per channel (1..32)
- CHANNELS, 4: number of channels (1..16)
- LATENCY, 2: DUT cycles from dut_in to dut_out (1..8)
- NUM_VECTORS, 16: vectors per run (1..65535)

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-low
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE
- invert  in  1  mode, sampled on start: 0 = expect passthrough, 1 = expect bitwise inverse
- dut_in  out  CHANNELS*WIDTH  stimulus; channel c occupies bits [c*WIDTH +: WIDTH]
- dut_out  in  CHANNELS*WIDTH  DUT response, same packing
- busy  out  1  high in RUN and DRAIN
- done  out  1  high in DONE
- pass  out  1  valid when done; 1 iff err_count == 0
- fail_pulse  out  1  one-cycle pulse per mismatching compare cycle
- err_count  out  16  mismatching channel-compares this run; saturates at 16'hFFFF
- first_err_vec  out  16  vector index of the first mismatch
- first_err_chan  out  4  lowest mismatching channel within the first mismatching vector

## Operation
- States are IDLE, RUN, DRAIN and DONE.
- IDLE: on start, go to RUN. Clear err_count, first_err_*, and the first-error-seen flag. Latch invert.
- RUN: each cycle, drive vector k, where k runs from 0 to NUM_VECTORS-1.
  - stim[c] = (k*CHANNELS + c) mod 2^WIDTH.
  - After k = NUM_VECTORS-1, go to DRAIN.
- DRAIN: drive dut_in = 0. Hold for exactly LATENCY cycles, then go to DONE.
- DONE: hold the results. start re-enters RUN with cleared results. start is ignored in RUN and DRAIN.
- dut_in = 0 in every state except RUN.
- Expected-value path:
  - exp[c] = stim[c] XOR {WIDTH{invert_latched}}.
  - The expected value and a valid bit enter a LATENCY-deep delay line.
  - A compare happens only when the delayed valid is 1, so exactly NUM_VECTORS compares occur per run.
- Compare cycle:
  - Each channel that mismatches adds 1 to err_count. Several mismatches in one cycle add their sum, clamped at 16'hFFFF.
  - fail_pulse = 1 if any channel mismatches.
  - On the first mismatching cycle of a run, latch first_err_vec (the delayed vector index) and first_err_chan (the lowest mismatching channel). These are never overwritten later in the run.
- pass = done & (err_count == 0). pass is 0 outside DONE.

## Timing
- Reset (reset == 0 at a clock edge) forces IDLE and sets all outputs to 0, including dut_in and the delay line.
- Reset mid-run aborts the run with no partial result retained.
- Start latency: start at edge t sets busy = 1 and dut_in = vector 0 from edge t onward (registered outputs).
- Vector k is driven in cycle t+k and compared in cycle t+k+LATENCY.
- A run from start to done takes NUM_VECTORS + LATENCY cycles. done rises at edge t+NUM_VECTORS+LATENCY.
- The last compare occurs in the final DRAIN cycle. Its errors are reflected in err_count in the same cycle that done rises.
- Simultaneous start and reset deassert: reset wins and the state stays IDLE.
- WIDTH < log2(NUM_VECTORS*CHANNELS): stimulus wraps modulo 2^WIDTH. This is legal, and the expected value wraps identically.

## Structure
- Shared package tb_pkg holds:
  - the state enum {IDLE, RUN, DRAIN, DONE}
  - the ERR_W = 16 constant
  - the saturating-add function
- Sub-module delay_line is parametrised by width and depth. It is instantiated once, carrying {valid, vector index, CHANNELS*WIDTH expected}, with reset clearing it to zeros.
- The top module holds the FSM, the vector counter, the stimulus generator, the per-channel comparators, the popcount and the error latch.

## Test plan
- Ideal passthrough model, CHANNELS=4, WIDTH=8, LATENCY=2, NUM_VECTORS=16, invert=0 -> done after 18 cycles, pass=1, err_count=0, fail_pulse never asserted.
- Same configuration with the model inverting, invert=1 -> pass=1. The same inverting model with invert=0 -> err_count=64, first_err_vec=0, first_err_chan=0.
- Model corrupts channel 2 only at vector 5 (flip bit 0) -> err_count=1, first_err_vec=5, first_err_chan=2, exactly one fail_pulse, 7 cycles after start.
- Model delays one cycle too long (LATENCY 3 versus parameter 2) -> pass=0; stimulus on dut_in matches the formula, including the wrap with WIDTH=4.
- reset low at cycle 8 of a run -> next cycle is IDLE with all outputs 0. A new start then gives a full clean run, pass=1.
- start pulsed during RUN and again in DONE -> the first is ignored; the second restarts and clears err_count from a previous failing run to 0.
